// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU load/store
// path (port 0) and the UART DMA engine (port 1). Every access runs a fixed
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP sequence, so that slower
// memories can be used by raising MEM_LAT. Port 1 may hold the port across
// back-to-back accesses with m1_lock. After MAX_BURST such grants, a waiting
// port 0 gets one access in.
//
// Build option: define DMEM_ARB_ROUND_ROBIN_EN to give a tie to the port that
// did not own the previous access. Leave it undefined for fixed priority, where
// port 0 wins every tie. The lock and the burst cap apply in both builds.
//
// Handshake: a master raises mN_req with mN_wr/mN_addr/mN_wdata valid and holds
// them until mN_ack pulses for exactly one cycle. The request fields are
// captured at grant and ignored after that. The shared rdata register is valid
// in the ack cycle. A req still high in the IDLE cycle after ack is taken as a
// new request.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy,
  output logic [1:0]        state_dbg
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Index of the last WAIT cycle; unused when MEM_LAT is 0.
  localparam logic [1:0] LAT_LAST = 2'((MEM_LAT == 0) ? 0 : MEM_LAT - 1);
  localparam logic [3:0] MAX_B    = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        wait_cnt_q;
  logic              cap_wr_q;    // captured direction of the access in flight
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        burst_q;     // consecutive locked port-1 grants
  logic              rr_q;        // port that wins the next tie
  logic              locked;
  logic              cap_hit;
  logic              grant_any;
  logic              grant_port;
  logic              grant_wr;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;
  logic              access_done;

  assign state_dbg   = state_q;
  assign m0_rdata    = rdata_q;
  assign m1_rdata    = rdata_q;
  assign grant_wr    = grant_port ? m1_wr    : m0_wr;
  assign grant_addr  = grant_port ? m1_addr  : m0_addr;
  assign grant_wdata = grant_port ? m1_wdata : m0_wdata;
  // Final edge of ISSUE/WAIT: read data is sampled and ack is raised here.
  assign access_done = (state_d == RESP);

  // State register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic for the fixed issue/wait/respond sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = ISSUE;
      ISSUE:   state_d = (MEM_LAT == 0) ? RESP : WAIT;
      WAIT:    if (wait_cnt_q == LAT_LAST) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Arbitration: lock (with burst cap), then tie-break, then the single requester.
  always_comb begin
    grant_port = 1'b0;
    locked     = owner & m1_lock & m1_req;
    cap_hit    = (burst_q == MAX_B) & m0_req;
    grant_any  = m0_req | m1_req;
    if (locked)               grant_port = ~cap_hit;
    else if (m0_req & m1_req) grant_port = RR_EN ? rr_q : 1'b0;
    else                      grant_port = m1_req;
  end

  // Access datapath: capture at grant, drive the memory strobes, sample, and ack.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cap_wr_q   <= 1'b0;
      owner      <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      rdata_q    <= '0;
      busy       <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      busy   <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            owner     <= grant_port;
            cap_wr_q  <= grant_wr;
            mem_addr  <= grant_addr;
            mem_wdata <= grant_wdata;
            mem_wr    <= grant_wr;
            mem_rd    <= ~grant_wr;
          end
        end
        ISSUE: begin
          mem_wr     <= 1'b0;
          wait_cnt_q <= '0;
        end
        WAIT:    wait_cnt_q <= wait_cnt_q + 2'd1;
        default: ;
      endcase
      if (access_done) begin
        mem_rd <= 1'b0;
        if (!cap_wr_q) rdata_q <= mem_rdata;
        m0_ack <= ~owner;
        m1_ack <= owner;
      end
    end
  end

  // Burst counter and round-robin pointer, both updated on each grant.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      burst_q <= '0;
      rr_q    <= 1'b0;
    end else if (state_q == IDLE && grant_any) begin
      rr_q <= ~grant_port;
      if (grant_port && m1_lock) begin
        if (!locked)               burst_q <= 4'd1;
        else if (burst_q != MAX_B) burst_q <= burst_q + 4'd1;
      end else begin
        burst_q <= '0;
      end
    end else if (!m1_lock) begin
      burst_q <= '0;
    end
  end

endmodule
